// File: rtl/i2s_tdm_transceiver.sv
// I2S / TDM audio serial port: clock generation, frame serialiser and deserialiser.
// Sits between the FIR core and the codec pins.
module i2s_tdm_transceiver #(
  parameter int DATA_WIDTH   = 24,
  parameter int SLOT_WIDTH   = 32,
  parameter int NUM_CHANNELS = 2,
  parameter int MCLK_HALF    = 2,
  parameter int SCLK_HALF    = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                tdmMode,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  txData,
  input  logic                                txValid,
  output logic                                txReady,
  output logic                                txUnderrun,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0]  rxData,
  output logic                                rxValid,
  output logic                                mclk,
  output logic                                sclk,
  output logic                                lrck,
  output logic                                dacData,
  input  logic                                adcData
);

  localparam int FB  = NUM_CHANNELS * SLOT_WIDTH;
  localparam int TW  = NUM_CHANNELS * DATA_WIDTH;
  localparam int MCW = $clog2(MCLK_HALF + 1);
  localparam int SCW = $clog2(SCLK_HALF + 1);
  localparam int PW  = $clog2(FB + 1);

  logic           run_q, run_d;
  logic [MCW-1:0] mc_q, mc_d;
  logic           mclk_q, mclk_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic           sclk_q, sclk_d;
  logic [PW-1:0]  p_q, p_d;
  logic           tdm_q, tdm_d;
  logic           lrck_q, lrck_d;
  logic           dac_q, dac_d;
  logic [FB-1:0]  sh_q, sh_d;
  logic [FB-1:0]  rsh_q, rsh_d;
  logic [TW-1:0]  hold_q, hold_d;
  logic           full_q, full_d;
  logic           und_q, und_d;
  logic           armed_q, armed_d;
  logic           pend_q, pend_d;
  logic [TW-1:0]  rxd_q, rxd_d;
  logic           rxv_q, rxv_d;

  logic          sc_top, mc_top, adv, rise, wrap, fstart, mode;
  logic          tx_rdy, capture;
  logic [FB-1:0] frame_ld;
  logic [TW-1:0] rx_word;

  always_comb begin
    sc_top  = (sc_q == SCW'(SCLK_HALF - 1));
    mc_top  = (mc_q == MCW'(MCLK_HALF - 1));
    adv     = run_q && sc_top && sclk_q;
    rise    = run_q && sc_top && !sclk_q;
    wrap    = adv && (p_q == PW'(FB - 1));
    fstart  = enable && (!run_q || wrap);
    mode    = fstart ? tdmMode : tdm_q;
    tx_rdy  = !full_q || fstart;
    capture = txValid && tx_rdy;

    // Slot c carries channel c MSB-first; frame bit 0 sits at the shifter MSB.
    frame_ld = '0;
    rx_word  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      frame_ld[FB-1-c*SLOT_WIDTH -: DATA_WIDTH] = hold_q[c*DATA_WIDTH +: DATA_WIDTH];
      rx_word[c*DATA_WIDTH +: DATA_WIDTH] = rsh_q[FB-1-c*SLOT_WIDTH -: DATA_WIDTH];
    end

    run_d   = run_q;
    mc_d    = mc_q;
    mclk_d  = mclk_q;
    sc_d    = sc_q;
    sclk_d  = sclk_q;
    p_d     = p_q;
    tdm_d   = tdm_q;
    lrck_d  = lrck_q;
    dac_d   = dac_q;
    sh_d    = sh_q;
    rsh_d   = rsh_q;
    hold_d  = hold_q;
    full_d  = full_q;
    und_d   = 1'b0;
    armed_d = armed_q;
    pend_d  = 1'b0;
    rxd_d   = rxd_q;
    rxv_d   = 1'b0;

    if (!enable) begin
      run_d   = 1'b0;
      mc_d    = '0;
      mclk_d  = 1'b0;
      sc_d    = '0;
      sclk_d  = 1'b0;
      p_d     = '0;
      tdm_d   = 1'b0;
      lrck_d  = 1'b0;
      dac_d   = 1'b0;
      sh_d    = '0;
      rsh_d   = '0;
      hold_d  = '0;
      full_d  = 1'b0;
      armed_d = 1'b0;
      rxd_d   = '0;
    end else begin
      run_d = 1'b1;
      if (run_q) begin
        if (mc_top) begin
          mc_d   = '0;
          mclk_d = !mclk_q;
        end else begin
          mc_d = mc_q + MCW'(1);
        end
        if (sc_top) begin
          sc_d   = '0;
          sclk_d = !sclk_q;
        end else begin
          sc_d = sc_q + SCW'(1);
        end
      end
      if (adv) p_d = wrap ? '0 : p_q + PW'(1);
      if (fstart) tdm_d = tdmMode;
      // dac in period 0 is still the previous frame's last bit.
      if (adv || fstart) begin
        lrck_d = mode ? (p_d == '0) : (p_d >= PW'(FB / 2));
        dac_d  = sh_q[FB-1];
        sh_d   = fstart ? (full_q ? frame_ld : '0) : (sh_q << 1);
      end
      und_d = fstart && !full_q;
      if (capture) begin
        hold_d = txData;
        full_d = 1'b1;
      end else if (fstart) begin
        full_d = 1'b0;
      end
      if (rise) rsh_d = {rsh_q[FB-2:0], adcData};
      if (wrap) armed_d = 1'b1;
      pend_d = rise && (p_q == '0) && armed_q;
      rxv_d  = pend_q;
      if (pend_q) rxd_d = rx_word;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_q   <= 1'b0;
      mc_q    <= '0;
      mclk_q  <= 1'b0;
      sc_q    <= '0;
      sclk_q  <= 1'b0;
      p_q     <= '0;
      tdm_q   <= 1'b0;
      lrck_q  <= 1'b0;
      dac_q   <= 1'b0;
      sh_q    <= '0;
      rsh_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      und_q   <= 1'b0;
      armed_q <= 1'b0;
      pend_q  <= 1'b0;
      rxd_q   <= '0;
      rxv_q   <= 1'b0;
    end else begin
      run_q   <= run_d;
      mc_q    <= mc_d;
      mclk_q  <= mclk_d;
      sc_q    <= sc_d;
      sclk_q  <= sclk_d;
      p_q     <= p_d;
      tdm_q   <= tdm_d;
      lrck_q  <= lrck_d;
      dac_q   <= dac_d;
      sh_q    <= sh_d;
      rsh_q   <= rsh_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      und_q   <= und_d;
      armed_q <= armed_d;
      pend_q  <= pend_d;
      rxd_q   <= rxd_d;
      rxv_q   <= rxv_d;
    end
  end

  assign txReady    = tx_rdy;
  assign txUnderrun = und_q;
  assign rxData     = rxd_q;
  assign rxValid    = rxv_q;
  assign mclk       = mclk_q;
  assign sclk       = sclk_q;
  assign lrck       = lrck_q;
  assign dacData    = dac_q;

endmodule

// File: tb/tb_i2s_tdm_transceiver.sv
// Directed bench: default I2S loopback, 8-ch TDM loopback, 16-bit data in 32-bit slots.
// Cycle k counts negedges after the first enabled posedge.
module tb_i2s_tdm_transceiver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        en_a, tdm_a, txv_a, txr_a, und_a, rxv_a;
  logic        mclk_a, sclk_a, lrck_a, dac_a;
  logic [47:0] txd_a, rxd_a;

  logic         en_t, tdm_t, txv_t, txr_t, und_t, rxv_t;
  logic         mclk_t, sclk_t, lrck_t, dac_t;
  logic [191:0] txd_t, rxd_t;

  logic        en_d, tdm_d, txv_d, txr_d, und_d, rxv_d;
  logic        mclk_d, sclk_d, lrck_d, dac_d;
  logic [31:0] txd_d, rxd_d;

  i2s_tdm_transceiver u_dut (
    .clk(clk), .reset(rst), .enable(en_a), .tdmMode(tdm_a),
    .txData(txd_a), .txValid(txv_a), .txReady(txr_a),
    .txUnderrun(und_a), .rxData(rxd_a), .rxValid(rxv_a),
    .mclk(mclk_a), .sclk(sclk_a), .lrck(lrck_a),
    .dacData(dac_a), .adcData(dac_a)
  );

  i2s_tdm_transceiver #(.NUM_CHANNELS(8)) u_tdm (
    .clk(clk), .reset(rst), .enable(en_t), .tdmMode(tdm_t),
    .txData(txd_t), .txValid(txv_t), .txReady(txr_t),
    .txUnderrun(und_t), .rxData(rxd_t), .rxValid(rxv_t),
    .mclk(mclk_t), .sclk(sclk_t), .lrck(lrck_t),
    .dacData(dac_t), .adcData(dac_t)
  );

  i2s_tdm_transceiver #(.DATA_WIDTH(16)) u_dw16 (
    .clk(clk), .reset(rst), .enable(en_d), .tdmMode(tdm_d),
    .txData(txd_d), .txValid(txv_d), .txReady(txr_d),
    .txUnderrun(und_d), .rxData(rxd_d), .rxValid(rxv_d),
    .mclk(mclk_d), .sclk(sclk_d), .lrck(lrck_d),
    .dacData(dac_d), .adcData(dac_d)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  localparam logic [47:0] DA = {24'hABCDEF, 24'h123456};
  localparam logic [47:0] DB = {24'h7FFFFE, 24'h800001};

  int          n_lr, n_rx, n_dac1, n_nrdy, n_und, last_rx;
  logic [63:0] fa, fb;
  logic [31:0] v16;

  initial begin
    rst = 1'b1;
    en_a = 0; tdm_a = 0; txv_a = 0; txd_a = '0;
    en_t = 0; tdm_t = 0; txv_t = 0; txd_t = '0;
    en_d = 0; tdm_d = 0; txv_d = 0; txd_d = '0;
    cyc = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", txr_a, 1);
    check("rst_outs", {mclk_a, sclk_a, lrck_a, dac_a, rxv_a, und_a}, 0);
    check("rst_rxdata", rxd_a, 0);

    // Run partway into a frame, then reset mid-frame.
    rst = 1'b0;
    @(negedge clk);
    en_a = 1'b1;
    cyc = -1;
    repeat (521) begin
      step();
      if (cyc == 1) check("mclk_c1", mclk_a, 0);
      if (cyc == 2) check("mclk_c2", mclk_a, 1);
      if (cyc == 7) check("sclk_c7", sclk_a, 0);
      if (cyc == 8) check("sclk_c8", sclk_a, 1);
    end
    check("pre_rst_lr_sc", {lrck_a, sclk_a}, 2'b11);
    rst = 1'b1;
    #1;
    check("midrst_outs", {mclk_a, sclk_a, lrck_a, dac_a, rxv_a, und_a}, 0);
    check("midrst_ready", txr_a, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = -1;

    // Three frames with nothing offered.
    n_lr = 0; n_rx = 0; n_dac1 = 0; n_nrdy = 0; n_und = 0; last_rx = 0;
    repeat (3072) begin
      step();
      if (cyc < 512 && lrck_a) n_lr++;
      if (cyc == 512) check("lrck_512", lrck_a, 1);
      if (cyc < 1024 && rxv_a) check("rx_first_frame", rxv_a, 0);
      if (rxv_a) begin
        n_rx++;
        last_rx = cyc;
        check("rx_zero", rxd_a, 0);
      end
      if (dac_a) n_dac1++;
      if (!txr_a) n_nrdy++;
      if (und_a) begin
        check("und_cycle", cyc, n_und * 1024);
        n_und++;
      end
    end
    check("lrck_low_512", n_lr, 0);
    check("rx_cnt_t1", n_rx, 2);
    check("dac_idle", n_dac1, 0);
    check("ready_idle", n_nrdy, 0);
    check("und_cnt", n_und, 3);

    // Continuous loopback traffic.
    n_rx = 0; n_und = 0;
    repeat (4128) begin
      step();
      if (cyc == 3092) begin
        txv_a = 1'b1;
        txd_a = DA;
      end
      if (und_a) n_und++;
      if (rxv_a) begin
        n_rx++;
        check("rx_gap", cyc - last_rx, 1024);
        last_rx = cyc;
        check("rx_loop", rxd_a, (cyc >= 5129) ? 64'(DA) : 64'd0);
      end
    end
    check("rx_cnt_t2", n_rx, 5);
    check("und_cnt_t2", n_und, 1);

    // Back-to-back offers from a fresh enable.
    en_a = 1'b0;
    txv_a = 1'b0;
    repeat (3) @(negedge clk);
    check("dis_outs", {mclk_a, sclk_a, lrck_a, dac_a, rxv_a, und_a}, 0);
    check("dis_ready", txr_a, 1);
    en_a = 1'b1;
    txv_a = 1'b1;
    txd_a = DA;
    cyc = -1;
    n_rx = 0; n_und = 0; fa = '0; fb = '0;
    repeat (3100) begin
      step();
      if (cyc == 0) begin
        check("b2b_ready_c0", txr_a, 0);
        txd_a = DB;
      end
      if (cyc == 1022) check("b2b_ready_1022", txr_a, 0);
      if (cyc == 1023) check("b2b_ready_1023", txr_a, 1);
      if (cyc == 1024) begin
        check("b2b_ready_1024", txr_a, 0);
        txv_a = 1'b0;
      end
      if (cyc % 16 == 8 && cyc >= 1048 && cyc <= 2056) fa = {fa[62:0], dac_a};
      if (cyc % 16 == 8 && cyc >= 2072 && cyc <= 3080) fb = {fb[62:0], dac_a};
      if (und_a) n_und++;
      if (rxv_a) begin
        n_rx++;
        if (cyc == 2057) check("b2b_rx_a", rxd_a, 64'(DA));
        if (cyc == 3081) check("b2b_rx_b", rxd_a, 64'(DB));
      end
    end
    check("b2b_dac_a", fa, 64'h12345600_ABCDEF00);
    check("b2b_dac_b", fb, 64'h80000100_7FFFFE00);
    check("b2b_und", n_und, 2);
    check("b2b_rx_cnt", n_rx, 3);
    en_a = 1'b0;

    // 8-channel TDM loopback.
    for (int c = 0; c < 8; c++) txd_t[c*24 +: 24] = 24'(c + 1);
    @(negedge clk);
    en_t = 1'b1;
    tdm_t = 1'b1;
    txv_t = 1'b1;
    cyc = -1;
    n_lr = 0; n_rx = 0;
    repeat (8300) begin
      step();
      if (cyc == 0) check("tdm_lr_c0", lrck_t, 1);
      if (cyc == 16) check("tdm_lr_c16", lrck_t, 0);
      if (cyc >= 4096 && cyc < 8192 && lrck_t) n_lr++;
      if (rxv_t) begin
        n_rx++;
        if (cyc == 8201)
          for (int c = 0; c < 8; c++)
            check($sformatf("tdm_slot%0d", c), rxd_t[c*24 +: 24], c + 1);
      end
    end
    check("tdm_lr_cnt", n_lr, 16);
    check("tdm_rx_cnt", n_rx, 2);
    en_t = 1'b0;

    // 16-bit samples in 32-bit slots.
    @(negedge clk);
    en_d = 1'b1;
    txv_d = 1'b1;
    txd_d = {16'h0000, 16'h8001};
    cyc = -1;
    v16 = '0;
    n_rx = 0;
    repeat (2070) begin
      step();
      if (cyc % 16 == 8 && cyc >= 1048 && cyc <= 1544) v16 = {v16[30:0], dac_d};
      if (rxv_d) begin
        n_rx++;
        if (cyc == 2057) check("dw16_rx", rxd_d, 32'h0000_8001);
      end
    end
    check("dw16_dac", v16, 32'h8001_0000);
    check("dw16_rx_cnt", n_rx, 2);
    en_d = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
